// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg
// Shared definitions for the iterative multiply/divide unit: operation
// codes, FSM state encodings and the iteration count.
package mult_div_unit_pkg;

  localparam int MD_WIDTH = 32;  // operand and HI/LO width
  localparam int MD_ITER  = 32;  // shift-add / restoring-divide iterations
  localparam int MD_CNT_W = 6;   // iteration counter width

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if
// Bundles the execute-stage side of the multiply/divide unit.
//   master (pipeline control): drives start/op/src_a/src_b and the
//                              MTHI/MTLO strobes; observes busy/done/hi/lo.
//   slave  (mult_div_unit):    the reverse.
interface mult_div_unit_if #(parameter int WIDTH = 32);

  logic             start;    // launch an operation (IDLE only)
  logic [1:0]       op;       // 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
  logic [WIDTH-1:0] src_a;    // multiplicand / dividend (rs)
  logic [WIDTH-1:0] src_b;    // multiplier / divisor (rt)
  logic             wr_hi;    // MTHI strobe
  logic             wr_lo;    // MTLO strobe
  logic [WIDTH-1:0] wr_data;  // MTHI/MTLO data
  logic             busy;     // operation in progress
  logic             done;     // one-cycle result pulse
  logic [WIDTH-1:0] hi;       // HI register
  logic [WIDTH-1:0] lo;       // LO register

  modport master (
    output start, op, src_a, src_b, wr_hi, wr_lo, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, wr_hi, wr_lo, wr_data,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/md_negate32.sv
// md_negate32
// Combinational conditional two's-complement negate.
//   neg : 1 = output -a, 0 = output a
//   a   : 32-bit input
//   z   : 32-bit result
module md_negate32 (
  input  logic        neg,
  input  logic [31:0] a,
  output logic [31:0] z
);

  assign z = neg ? (~a + 32'd1) : a;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO
// registers. Operands are reduced to magnitudes at launch, 32 iterations of
// shift-add (multiply) or restoring division run on a 64-bit working
// register, and a final FIX cycle applies the sign correction and writes
// HI/LO in one step.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   md  : slave side of mult_div_unit_if (start/op/operands, MTHI/MTLO,
//         busy/done, hi/lo)
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  mult_div_unit_if.slave  md
);

  md_state_e             state_q, state_d;
  md_op_e                op_q;
  logic [MD_CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]      operand_q;   // |multiplicand| or |divisor|
  logic [2*WIDTH-1:0]    work_q, work_d;
  logic                  neg_lo_q;    // negate LO (product / quotient)
  logic                  neg_hi_q;    // negate HI (product / remainder)
  logic                  dz_q;        // divide by zero seen at launch
  logic [WIDTH-1:0]      a_raw_q;     // raw dividend for divide-by-zero HI
  logic [WIDTH-1:0]      hi_q, hi_d, lo_q, lo_d;
  logic                  done_q;

  // ---------------- launch-side operand conditioning ----------------
  logic             launch;
  logic             in_signed, in_div, sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign launch    = (state_q == MD_IDLE) && md.start;
  assign in_signed = (md.op == MD_MULT) || (md.op == MD_DIV);
  assign in_div    = (md.op == MD_DIV)  || (md.op == MD_DIVU);
  assign sign_a    = in_signed & md.src_a[WIDTH-1];
  assign sign_b    = in_signed & md.src_b[WIDTH-1];

  md_negate32 u_abs_a (.neg(sign_a), .a(md.src_a), .z(abs_a));
  md_negate32 u_abs_b (.neg(sign_b), .a(md.src_b), .z(abs_b));

  // ---------------- shared 33-bit adder/subtractor ----------------
  logic             is_div;
  logic [WIDTH:0]   rem_shift;        // {rem, quo[31]}: remainder after left shift
  logic [WIDTH:0]   add_x, add_y, sum;
  logic             trial_ok;

  assign is_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);
  assign rem_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};

  // Divide subtracts via x + ~y + 1; multiply adds the multiplicand only
  // when the current multiplier LSB is set.
  assign add_x = is_div ? rem_shift : {1'b0, work_q[2*WIDTH-1:WIDTH]};
  assign add_y = is_div ? ~{1'b0, operand_q}
                        : (work_q[0] ? {1'b0, operand_q} : '0);
  assign sum   = add_x + add_y + {{WIDTH{1'b0}}, is_div};

  // rem < divisor always holds, so the trial result is non-negative exactly
  // when no borrow reaches bit 32.
  assign trial_ok = ~sum[WIDTH];

  always_comb begin
    work_d = work_q;
    if (launch) begin
      // Multiply: {acc=0, mplr=|b|}, operand=|a|.
      // Divide:   {rem=0, quo=|a|}, operand=|b|.
      work_d = {{WIDTH{1'b0}}, in_div ? abs_a : abs_b};
    end else if (state_q == MD_RUN) begin
      if (is_div) begin
        work_d = {(trial_ok ? sum[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                  work_q[WIDTH-2:0], trial_ok};
      end else begin
        work_d = {sum, work_q[WIDTH-1:1]};
      end
    end
  end

  // ---------------- FIX-stage sign correction ----------------
  logic [WIDTH-1:0] hi_raw, lo_raw, lo_fix, hi_neg, hi_fix;
  logic             lo_zero, hi_neg_en, hi_inv_only;

  assign hi_raw  = work_q[2*WIDTH-1:WIDTH];
  assign lo_raw  = work_q[WIDTH-1:0];
  assign lo_zero = (lo_raw == '0);

  // A 64-bit product negate is ~{hi,lo}+1: the +1 carries into HI only when
  // LO is zero, otherwise HI is just inverted.
  assign hi_neg_en   = neg_hi_q && (is_div || lo_zero);
  assign hi_inv_only = !is_div && neg_hi_q && !lo_zero;

  md_negate32 u_fix_lo (.neg(neg_lo_q),  .a(lo_raw), .z(lo_fix));
  md_negate32 u_fix_hi (.neg(hi_neg_en), .a(hi_raw), .z(hi_neg));

  assign hi_fix = hi_inv_only ? ~hi_raw : hi_neg;

  // ---------------- HI/LO next state ----------------
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == MD_FIX) begin
      if (dz_q) begin
        hi_d = a_raw_q;
        lo_d = '1;
      end else begin
        hi_d = hi_fix;
        lo_d = lo_fix;
      end
    end else if ((state_q == MD_IDLE) && !md.start) begin
      if (md.wr_hi) hi_d = md.wr_data;
      if (md.wr_lo) lo_d = md.wr_data;
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (md.start) state_d = MD_RUN;
      MD_RUN:  if (cnt_q == MD_CNT_W'(MD_ITER - 1)) state_d = MD_FIX;
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= MD_MULT;
      cnt_q     <= '0;
      operand_q <= '0;
      work_q    <= '0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      dz_q      <= 1'b0;
      a_raw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      work_q <= work_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= (state_q == MD_FIX);
      if (launch) begin
        op_q      <= md_op_e'(md.op);
        cnt_q     <= '0;
        operand_q <= in_div ? abs_b : abs_a;
        neg_lo_q  <= sign_a ^ sign_b;
        neg_hi_q  <= in_div ? sign_a : (sign_a ^ sign_b);
        dz_q      <= in_div && (md.src_b == '0);
        a_raw_q   <= md.src_a;
      end else if (state_q == MD_RUN) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign md.busy = (state_q != MD_IDLE);
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule
